// File: rtl/counter_timer_multi_if.sv
// Register-access bundle for counter_timer_multi: per-channel write strobes,
// channel select, write data, readback data, and the tick/irq output vectors.
// master = bus/decode side, slave = the timer peripheral.
interface counter_timer_multi_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 2,
  parameter int AW    = (NCH > 1) ? $clog2(NCH) : 1
);

  logic [AW-1:0]    addr;
  logic             cfg_we;
  logic             val_we;
  logic             dat_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata_cnt;
  logic [4:0]       rdata_cfg;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   irq;

  modport master (
    output addr, cfg_we, val_we, dat_we, wdata,
    input  rdata_cnt, rdata_cfg, tick, irq
  );

  modport slave (
    input  addr, cfg_we, val_we, dat_we, wdata,
    output rdata_cnt, rdata_cfg, tick, irq
  );

endinterface

// File: rtl/counter_timer_multi.sv
// counter_timer_multi: NCH independent WIDTH-bit counter/timer channels.
// Each channel counts up or down, runs one-shot or continuous, raises a
// one-cycle tick and a sticky irq on its terminal event.
// Optional feature macro: TIMER_CHAIN_EN -- when defined, config bit 4
// (chain) makes channel k count only on channel k-1's terminal event in the
// same cycle. When undefined, no chain state or inter-channel logic exists.
module counter_timer_multi #(
  parameter int WIDTH = 32,
  parameter int NCH   = 2,
  parameter int AW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clkin,
  input  logic                  reset,
  counter_timer_multi_if.slave  bus
);

  // Architectural state
  logic [WIDTH-1:0] cnt      [NCH];
  logic [WIDTH-1:0] value    [NCH];
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   oneshot;
  logic [NCH-1:0]   up;
  logic [NCH-1:0]   irq_en;
`ifdef TIMER_CHAIN_EN
  logic [NCH-1:0]   chain;
`endif
  logic [NCH-1:0]   tick_r;
  logic [NCH-1:0]   irq_r;

  // Next-state values
  logic [WIDTH-1:0] cnt_nxt     [NCH];
  logic [WIDTH-1:0] value_nxt   [NCH];
  logic [NCH-1:0]   en_nxt;
  logic [NCH-1:0]   oneshot_nxt;
  logic [NCH-1:0]   up_nxt;
  logic [NCH-1:0]   irq_en_nxt;
`ifdef TIMER_CHAIN_EN
  logic [NCH-1:0]   chain_nxt;
`endif
  logic [NCH-1:0]   tick_nxt;
  logic [NCH-1:0]   irq_nxt;

  // Per-channel decode and count/terminal events
  logic [NCH-1:0]   cfg_hit;
  logic [NCH-1:0]   val_hit;
  logic [NCH-1:0]   dat_hit;
  logic [NCH-1:0]   term;
  logic [NCH-1:0]   ce;
  logic [NCH-1:0]   te;

  // Decode the write strobes against the channel select
  always_comb begin
    cfg_hit = '0;
    val_hit = '0;
    dat_hit = '0;
    for (int k = 0; k < NCH; k++) begin
      cfg_hit[k] = bus.cfg_we && (bus.addr == AW'(k));
      val_hit[k] = bus.val_we && (bus.addr == AW'(k));
      dat_hit[k] = bus.dat_we && (bus.addr == AW'(k));
    end
  end

  // Count and terminal events; a chained channel sees its predecessor's te
  // in the same cycle, and a direct counter write suppresses te so that
  // neither this channel nor anything chained after it reacts.
  always_comb begin
`ifdef TIMER_CHAIN_EN
    logic prev_te;
    prev_te = 1'b0;
`endif
    term = '0;
    ce   = '0;
    te   = '0;
    for (int k = 0; k < NCH; k++) begin
      term[k] = up[k] ? (cnt[k] == value[k]) : (cnt[k] == '0);
`ifdef TIMER_CHAIN_EN
      if ((k > 0) && chain[k])
        ce[k] = en[k] & prev_te;
      else
        ce[k] = en[k];
`else
      ce[k] = en[k];
`endif
      te[k] = ce[k] & term[k] & ~dat_hit[k];
`ifdef TIMER_CHAIN_EN
      prev_te = te[k];
`endif
    end
  end

  // Next-state logic for every channel
  always_comb begin
    cnt_nxt     = cnt;
    value_nxt   = value;
    en_nxt      = en;
    oneshot_nxt = oneshot;
    up_nxt      = up;
    irq_en_nxt  = irq_en;
`ifdef TIMER_CHAIN_EN
    chain_nxt   = chain;
`endif
    irq_nxt     = irq_r;
    tick_nxt    = te;
    for (int k = 0; k < NCH; k++) begin
      // Counter: direct write beats reload/hold beats increment/decrement
      if (dat_hit[k]) begin
        cnt_nxt[k] = bus.wdata;
      end else if (te[k]) begin
        if (!oneshot[k])
          cnt_nxt[k] = up[k] ? '0 : value[k];
      end else if (ce[k]) begin
        cnt_nxt[k] = up[k] ? (cnt[k] + WIDTH'(1)) : (cnt[k] - WIDTH'(1));
      end

      if (val_hit[k])
        value_nxt[k] = bus.wdata;

      // One-shot completion drops en, but a same-cycle config write wins
      if (te[k] && oneshot[k])
        en_nxt[k] = 1'b0;
      if (cfg_hit[k]) begin
        en_nxt[k]      = bus.wdata[0];
        oneshot_nxt[k] = bus.wdata[1];
        up_nxt[k]      = bus.wdata[2];
        irq_en_nxt[k]  = bus.wdata[3];
`ifdef TIMER_CHAIN_EN
        chain_nxt[k]   = bus.wdata[4];
`endif
      end

      // Sticky irq: clear on irq_clr, but a simultaneous set wins
      if (cfg_hit[k] && bus.wdata[5])
        irq_nxt[k] = 1'b0;
      if (te[k] && irq_en[k])
        irq_nxt[k] = 1'b1;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        cnt[k]   <= '0;
        value[k] <= '0;
      end
      en      <= '0;
      oneshot <= '0;
      up      <= '0;
      irq_en  <= '0;
`ifdef TIMER_CHAIN_EN
      chain   <= '0;
`endif
      tick_r  <= '0;
      irq_r   <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        cnt[k]   <= cnt_nxt[k];
        value[k] <= value_nxt[k];
      end
      en      <= en_nxt;
      oneshot <= oneshot_nxt;
      up      <= up_nxt;
      irq_en  <= irq_en_nxt;
`ifdef TIMER_CHAIN_EN
      chain   <= chain_nxt;
`endif
      tick_r  <= tick_nxt;
      irq_r   <= irq_nxt;
    end
  end

  // Readback mux of the addressed channel; unmapped addresses read 0
  always_comb begin
    bus.rdata_cnt = '0;
    bus.rdata_cfg = '0;
    for (int k = 0; k < NCH; k++) begin
      if (bus.addr == AW'(k)) begin
        bus.rdata_cnt = cnt[k];
`ifdef TIMER_CHAIN_EN
        bus.rdata_cfg = {chain[k], irq_en[k], up[k], oneshot[k], en[k]};
`else
        bus.rdata_cfg = {1'b0, irq_en[k], up[k], oneshot[k], en[k]};
`endif
      end
    end
  end

  assign bus.tick = tick_r;
  assign bus.irq  = irq_r;

endmodule

// File: tb/tb_counter_timer_multi.sv
// Directed testbench for counter_timer_multi (WIDTH=32, NCH=2).
// Expected values are hand-computed cycle by cycle from the timer behaviour.
module tb_counter_timer_multi;

  localparam int WIDTH = 32;
  localparam int NCH   = 2;
  localparam int AW    = 1;

  logic clkin = 1'b0;
  logic reset;

  always #5 clkin = ~clkin;

  counter_timer_multi_if #(.WIDTH(WIDTH), .NCH(NCH), .AW(AW)) bus ();

  counter_timer_multi #(.WIDTH(WIDTH), .NCH(NCH), .AW(AW)) dut (
    .clkin (clkin),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic sel(input int ch);
    bus.addr = AW'(ch);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_cfg(input int ch, input logic [31:0] d);
    bus.addr = AW'(ch); bus.wdata = d; bus.cfg_we = 1'b1;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic wr_val(input int ch, input logic [31:0] d);
    bus.addr = AW'(ch); bus.wdata = d; bus.val_we = 1'b1;
    step();
    bus.val_we = 1'b0;
  endtask

  task automatic wr_dat(input int ch, input logic [31:0] d);
    bus.addr = AW'(ch); bus.wdata = d; bus.dat_we = 1'b1;
    step();
    bus.dat_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int ticks;
    reset      = 1'b1;
    bus.addr   = '0;
    bus.cfg_we = 1'b0;
    bus.val_we = 1'b0;
    bus.dat_we = 1'b0;
    bus.wdata  = '0;
    repeat (2) @(posedge clkin);
    #1;
    reset = 1'b0;
    step();

    // Reset state
    sel(0);
    chk("rst_cnt0", bus.rdata_cnt, 32'h0);
    chk("rst_cfg0", bus.rdata_cfg, 32'h0);
    sel(1);
    chk("rst_cnt1", bus.rdata_cnt, 32'h0);
    chk("rst_tick", bus.tick, 32'h0);
    chk("rst_irq", bus.irq, 32'h0);

    // Ch0 down continuous, value 0x11: tick every 18 cycles
    wr_val(0, 32'h11);
    wr_dat(0, 32'h11);
    wr_cfg(0, 32'h01);
    chk("t1_start", bus.rdata_cnt, 32'h11);
    step();
    chk("t1_first_dec", bus.rdata_cnt, 32'h10);
    ticks = 0;
    for (int i = 2; i <= 17; i++) begin
      step();
      if (bus.tick[0]) ticks++;
    end
    chk("t1_cnt_zero", bus.rdata_cnt, 32'h0);
    chk("t1_no_early_tick", ticks, 32'd0);
    step();
    chk("t1_tick", bus.tick[0], 32'h1);
    chk("t1_reload", bus.rdata_cnt, 32'h11);
    ticks = 0;
    for (int i = 1; i <= 17; i++) begin
      step();
      if (bus.tick[0]) ticks++;
    end
    chk("t1_p2_no_tick", ticks, 32'd0);
    step();
    chk("t1_p2_tick", bus.tick[0], 32'h1);
    chk("t1_p2_reload", bus.rdata_cnt, 32'h11);
    chk("t1_irq_off", bus.irq[0], 32'h0);
    wr_cfg(0, 32'h00);
    step();
    chk("t1_stopped", bus.rdata_cnt, 32'h10);

    // Ch1 one-shot down with irq
    wr_dat(1, 32'h0f);
    wr_cfg(1, 32'h0b);
    ticks = 0;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (bus.tick[1]) ticks++;
    end
    chk("t2_no_early_tick", ticks, 32'd0);
    chk("t2_cnt_zero", bus.rdata_cnt, 32'h0);
    step();
    chk("t2_tick", bus.tick[1], 32'h1);
    chk("t2_irq", bus.irq[1], 32'h1);
    chk("t2_hold", bus.rdata_cnt, 32'h0);
    chk("t2_en_clr", bus.rdata_cfg, 32'h0a);
    ticks = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (bus.tick[1]) ticks++;
    end
    chk("t2_single_tick", ticks, 32'd0);
    chk("t2_irq_sticky", bus.irq[1], 32'h1);
    chk("t2_still_zero", bus.rdata_cnt, 32'h0);
    wr_cfg(1, 32'h20);
    chk("t2_irq_clr", bus.irq[1], 32'h0);

    // Ch0 up continuous, value 0x0f
    wr_val(0, 32'h0f);
    wr_dat(0, 32'h00);
    wr_cfg(0, 32'h05);
    chk("t3_cfg", bus.rdata_cfg, 32'h05);
    ticks = 0;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (bus.tick[0]) ticks++;
    end
    chk("t3_top", bus.rdata_cnt, 32'h0f);
    chk("t3_no_early_tick", ticks, 32'd0);
    step();
    chk("t3_tick", bus.tick[0], 32'h1);
    chk("t3_wrap0", bus.rdata_cnt, 32'h0);
    step();
    chk("t3_next", bus.rdata_cnt, 32'h1);
    chk("t3_tick_pulse", bus.tick[0], 32'h0);
    wr_cfg(0, 32'h00);

    // Ch1 up, value 0: te every cycle; irq set beats irq_clr
    wr_val(1, 32'h0);
    wr_dat(1, 32'h0);
    wr_cfg(1, 32'h0d);
    step();
    chk("tv0_tick_a", bus.tick[1], 32'h1);
    chk("tv0_irq", bus.irq[1], 32'h1);
    step();
    chk("tv0_tick_b", bus.tick[1], 32'h1);
    chk("tv0_cnt", bus.rdata_cnt, 32'h0);
    wr_cfg(1, 32'h2d);
    chk("tv0_set_wins", bus.irq[1], 32'h1);
    wr_cfg(1, 32'h20);
    chk("tv0_set_wins2", bus.irq[1], 32'h1);
    wr_cfg(1, 32'h20);
    chk("tv0_cleared", bus.irq[1], 32'h0);
    chk("tv0_no_tick", bus.tick[1], 32'h0);

    // Chained channels (or standalone when chaining is compiled out)
    wr_dat(1, 32'h12b4);
    wr_val(0, 32'h3);
    wr_dat(0, 32'h3);
    wr_cfg(1, 32'h11);
    wr_cfg(0, 32'h01);
`ifdef TIMER_CHAIN_EN
    sel(1);
    chk("t4_ch1_held", bus.rdata_cnt, 32'h12b4);
    chk("t4_cfg1", bus.rdata_cfg, 32'h11);
    repeat (4) step();
    chk("t4_ch0_tick", bus.tick[0], 32'h1);
    sel(1);
    chk("t4_ch1_first", bus.rdata_cnt, 32'h12b3);
    repeat (36) step();
    sel(1);
    chk("t4_ch1_40", bus.rdata_cnt, 32'h12aa);
`else
    sel(1);
    chk("t4_ch1_first", bus.rdata_cnt, 32'h12b3);
    chk("t4_cfg1", bus.rdata_cfg, 32'h01);
    repeat (40) step();
    sel(1);
    chk("t4_ch1_40", bus.rdata_cnt, 32'h128b);
`endif
    wr_cfg(0, 32'h00);
    wr_cfg(1, 32'h00);

    // Direct counter write while idle, then coinciding with te
    wr_dat(0, 32'hdcba7cf3);
    chk("t5_dat", bus.rdata_cnt, 32'hdcba7cf3);
    repeat (3) step();
    chk("t5_stable", bus.rdata_cnt, 32'hdcba7cf3);
    wr_val(0, 32'h5);
    wr_dat(0, 32'h2);
    wr_cfg(0, 32'h09);
    step();
    step();
    chk("t5_at_zero", bus.rdata_cnt, 32'h0);
    wr_dat(0, 32'h40);
    chk("t5_write_wins", bus.rdata_cnt, 32'h40);
    chk("t5_no_tick", bus.tick[0], 32'h0);
    chk("t5_no_irq", bus.irq[0], 32'h0);
    step();
    chk("t5_continues", bus.rdata_cnt, 32'h3f);
    chk("t5_en_kept", bus.rdata_cfg, 32'h09);
    wr_cfg(0, 32'h00);

    // Asynchronous reset mid-count with irq pending
    wr_val(0, 32'h100);
    wr_dat(0, 32'h100);
    wr_cfg(0, 32'h01);
    wr_dat(1, 32'h1);
    wr_cfg(1, 32'h0b);
    step();
    step();
    chk("t6_irq_before", bus.irq[1], 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_irq_rst", bus.irq, 32'h0);
    chk("t6_tick_rst", bus.tick, 32'h0);
    sel(0);
    chk("t6_cnt0_rst", bus.rdata_cnt, 32'h0);
    chk("t6_cfg0_rst", bus.rdata_cfg, 32'h0);
    @(posedge clkin);
    #1;
    reset = 1'b0;
    repeat (4) step();
    sel(0);
    chk("t6_idle_cnt", bus.rdata_cnt, 32'h0);
    chk("t6_idle_tick", bus.tick, 32'h0);
    wr_dat(0, 32'h5);
    repeat (3) step();
    chk("t6_no_count", bus.rdata_cnt, 32'h5);
    chk("t6_cfg_clear", bus.rdata_cfg, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_timer_multi.md
# counter_timer_multi

Multi-channel, parametrised counter/timer peripheral for the management SoC. It generalises the single 32-bit counter/timer to NCH independent channels of WIDTH bits. Each channel supports up/down counting, one-shot or continuous mode, sticky interrupts and optional cascading into the next channel. It sits on the mgmt wishbone register decode, behind a simple per-channel write-strobe interface. Its `irq` outputs feed the CPU interrupt vector.

## Interface
Parameters:
- `WIDTH`, 32: counter and value register width.
- `NCH`, 2: number of channels (≥1).
- `AW`, `$clog2(NCH)` (min 1): channel address width.

Ports:
- `clkin`, in, 1: single clock; all state on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `addr`, in, AW: channel select for writes and reads.
- `cfg_we`, in, 1: write `wdata[5:0]` to the addressed channel's config.
- `val_we`, in, 1: write `wdata` to the addressed channel's value (reload/compare) register.
- `dat_we`, in, 1: write `wdata` directly to the addressed channel's counter.
- `wdata`, in, WIDTH: write data.
- `rdata_cnt`, out, WIDTH: counter of the addressed channel (combinational mux of registers).
- `rdata_cfg`, out, 5: config bits [4:0] of the addressed channel.
- `tick`, out, NCH: one-cycle terminal-count pulse per channel (registered).
- `irq`, out, NCH: sticky interrupt per channel (registered).

## Operation
Config bits per channel:
- [0] `en`.
- [1] `oneshot`: 1 = one-shot, 0 = continuous.
- [2] `up`: 1 = up, 0 = down.
- [3] `irq_en`.
- [4] `chain`.
- [5] `irq_clr`: write-1-clears `irq`; not stored, reads absent.

Count event `ce[k]`:
- `chain`=0: `ce[k] = en`.
- `chain`=1: `ce[k] = en & te[k-1]`, where `te` is the combinational terminal event of channel k-1 in the same cycle.
- Channel 0 ignores `chain`.

Terminal event `te[k]`:
- Down: `ce & (cnt == 0)`.
- Up: `ce & (cnt == value)`.

On `ce` without `te`: `cnt` ± 1, modulo 2^WIDTH.

On `te`:
- Continuous: reload. Down loads `value`; up loads 0.
- One-shot: hold `cnt` (0 down, `value` up) and clear `en`.
- In both modes, next cycle `tick[k]` = 1; `irq[k]` is set if `irq_en`.

Writes:
- `dat_we` and `val_we` take effect on the next edge.
- `cfg_we` with `irq_clr`=1 clears `irq[k]`.

## Timing
- Reset: every `cnt`, `value` and `cfg` = 0; `tick` = 0; `irq` = 0.
- Reset mid-count aborts immediately and asynchronously.
- Enable latency: a `cfg_we` setting `en` at edge N gives the first `ce` on the cycle after edge N. The first decrement is visible after edge N+1.
- Down continuous, `value` = V: `te` every V+1 count events.
- Up continuous, `value` = V: `te` every V+1 count events.
- `tick` and `irq` lag the terminal event by one cycle. A chained channel updates in the same cycle as its predecessor's reload, not delayed.
- `dat_we` to a channel in the same cycle as its `te`: the write wins. No reload, no `tick`, no `irq`, and `en` is not cleared. The downstream chain sees no `te`.
- `cfg_we` in the same cycle as a one-shot `te`: the written `en` wins.
- `irq_clr` in the same cycle as an irq-setting `te`: set wins and `irq` stays 1.
- Up mode with `cnt` > `value`: counts up, wraps through 2^WIDTH−1 → 0, then reaches `value`.
- `value` = 0: down mode gives `te` every cycle; up mode gives `te` every cycle.

## Configuration
- `TIMER_CHAIN_EN` defined: `chain` bit implemented as above.
- `TIMER_CHAIN_EN` undefined:
  - `chain` is not stored and `rdata_cfg[4]` reads 0.
  - Every channel counts standalone; `ce[k] = en`.
  - No inter-channel logic is synthesised.

## Test plan
1. Ch0 down continuous: `value`=0x11, `dat`=0x11, `en`=1 → `tick[0]` every 18 cycles. After each tick, `rdata_cnt` = 0x11 and the count sequence is 0x11…0x00.
2. Ch1 one-shot down: `dat`=0x0f, `irq_en`=1 → exactly one `tick[1]`; `cnt` holds 0; `rdata_cfg[0]` = 0; `irq[1]` = 1. Then `cfg_we` with `irq_clr` → `irq[1]` = 0.
3. Ch0 up continuous: `value`=0x0f, `dat`=0 → `cnt` cycles 0..0x0f; `tick` every 16 cycles; `cnt` = 0 after each tick.
4. `TIMER_CHAIN_EN` defined: ch0 down continuous with `value`=3; ch1 chained down with `dat`=0x12b4 → ch1 decrements once per 4 cycles. After 40 cycles ch1 = 0x12aa. With the macro undefined, ch1 decrements every cycle.
5. `dat_we` 0xdcba7cf3 while `en`=0 → `rdata_cnt` = 0xdcba7cf3 and stays stable. `dat_we` coinciding with `te` → written value loaded, `tick` stays 0.
6. Assert `reset` mid-count with `irq` set → all outputs and registers 0 immediately. After release, nothing counts until `en` is rewritten.
